// File: rtl/aucohl_serial_pkg.sv
// -----------------------------------------------------------------------------
// aucohl_serial_pkg
// Shared definitions for the aucohl serial transmit path.
//   tx_state_t  : FSM state encoding (IDLE=0 .. STOP=4)
//   IDLE_LEVEL  : line level while idle and during stop bits
//   START_LEVEL : line level of the start bit
// -----------------------------------------------------------------------------
package aucohl_serial_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/aucohl_serial_tx_if.sv
// -----------------------------------------------------------------------------
// aucohl_serial_tx_if
// Read side of a first-word-fall-through FIFO as seen by the transmitter.
//   fifo_empty : FIFO empty flag (FIFO -> transmitter)
//   fifo_rdata : FIFO head word, valid while fifo_empty=0 (FIFO -> transmitter)
//   fifo_rd    : one-cycle pop strobe (transmitter -> FIFO)
// Modports: master = transmitter (consumer), slave = FIFO.
// -----------------------------------------------------------------------------
interface aucohl_serial_tx_if #(
    parameter int DW = 8
);
    logic          fifo_empty;
    logic [DW-1:0] fifo_rdata;
    logic          fifo_rd;

    modport master (input fifo_empty, input fifo_rdata, output fifo_rd);
    modport slave  (output fifo_empty, output fifo_rdata, input fifo_rd);
endinterface

// File: rtl/aucohl_bit_timer.sv
// -----------------------------------------------------------------------------
// aucohl_bit_timer
// Programmable bit-period down-counter. Loading with prescale makes the
// following bit last prescale+1 clocks; bit_end is high in the last clock.
//   clk      : system clock
//   clr      : synchronous clear, active-high
//   load     : reload the counter with prescale (asserted on bit entry)
//   prescale : bit period minus one
//   bit_end  : current bit ends this clock
// -----------------------------------------------------------------------------
module aucohl_bit_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] prescale,
    output logic         bit_end
);
    import aucohl_serial_pkg::*;

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= prescale;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign bit_end = (r_cnt == '0);

endmodule

// File: rtl/aucohl_serial_tx.sv
// -----------------------------------------------------------------------------
// aucohl_serial_tx
// UART-style transmitter draining a FWFT FIFO, LSB-first, optional parity,
// one or two stop bits.
//   clk, rst   : clock, synchronous active-high reset
//   en         : frames start only while high
//   prescale   : bit period = prescale+1 clocks (latched per frame)
//   parity_en  : append parity bit;  parity_odd : odd (1) / even (0) parity
//   two_stop   : two stop bits (1) / one (0)
//   fifo       : FIFO read port (empty, rdata, rd)
//   tx         : registered serial line, idle high
//   busy       : frame in progress
//   done       : one-cycle pulse in the first IDLE cycle after a frame
// -----------------------------------------------------------------------------
module aucohl_serial_tx
    import aucohl_serial_pkg::*;
#(
    parameter int DW = 8,
    parameter int W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [W-1:0]             prescale,
    input  logic                     parity_en,
    input  logic                     parity_odd,
    input  logic                     two_stop,
    aucohl_serial_tx_if.master       fifo,
    output logic                     tx,
    output logic                     busy,
    output logic                     done
);
    tx_state_t     r_state;
    logic          r_tx;
    logic          r_done;
    logic [3:0]    r_bitcnt;
    logic [DW-1:0] r_shift;
    logic          r_par_bit;
    logic [W-1:0]  r_cfg_prescale;
    logic          r_cfg_par_en;
    logic          r_cfg_two_stop;

    logic          w_fifo_rd;
    logic          w_busy;
    logic          w_bit_end;
    logic          w_tmr_load;
    logic [W-1:0]  w_tmr_prescale;

    // Pop is gated by rst so a FIFO word is never consumed while in reset.
    assign w_fifo_rd    = (r_state == IDLE) & en & ~fifo.fifo_empty & ~rst;
    assign fifo.fifo_rd = w_fifo_rd;
    assign w_busy       = (r_state != IDLE);

    // The start bit is loaded in the IDLE cycle, before the config register
    // holds the new prescale, so take it straight from the input there.
    assign w_tmr_prescale = (r_state == IDLE) ? prescale : r_cfg_prescale;
    assign w_tmr_load     = w_fifo_rd | (w_busy & w_bit_end);

    aucohl_bit_timer #(.W(W)) u_timer (
        .clk      (clk),
        .clr      (rst),
        .load     (w_tmr_load),
        .prescale (w_tmr_prescale),
        .bit_end  (w_bit_end)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_tx     <= IDLE_LEVEL;
            r_done   <= 1'b0;
            r_bitcnt <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_fifo_rd) begin
                        r_shift        <= fifo.fifo_rdata;
                        // Parity is fixed at pop time so later config changes cannot leak in.
                        r_par_bit      <= (^fifo.fifo_rdata) ^ parity_odd;
                        r_cfg_prescale <= prescale;
                        r_cfg_par_en   <= parity_en;
                        r_cfg_two_stop <= two_stop;
                        r_tx           <= START_LEVEL;
                        r_state        <= START;
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        r_tx     <= r_shift[0];
                        r_bitcnt <= '0;
                        r_state  <= DATA;
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        if (r_bitcnt == 4'(DW - 1)) begin
                            r_bitcnt <= '0;
                            if (r_cfg_par_en) begin
                                r_tx    <= r_par_bit;
                                r_state <= PARITY;
                            end else begin
                                r_tx    <= IDLE_LEVEL;
                                r_state <= STOP;
                            end
                        end else begin
                            // tx already shows shift[0]; present the next bit.
                            r_tx     <= r_shift[1];
                            r_shift  <= {1'b0, r_shift[DW-1:1]};
                            r_bitcnt <= r_bitcnt + 4'd1;
                        end
                    end
                end
                PARITY: begin
                    if (w_bit_end) begin
                        r_tx     <= IDLE_LEVEL;
                        r_bitcnt <= '0;
                        r_state  <= STOP;
                    end
                end
                STOP: begin
                    if (w_bit_end) begin
                        if (r_cfg_two_stop && (r_bitcnt == 4'd0)) begin
                            r_bitcnt <= 4'd1;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    r_tx    <= IDLE_LEVEL;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign tx   = r_tx;
    assign busy = w_busy;
    assign done = r_done;

endmodule

// File: tb/tb_aucohl_serial_tx.sv
// -----------------------------------------------------------------------------
// tb_aucohl_serial_tx
// Directed bench for aucohl_serial_tx. A small FWFT FIFO model feeds the DUT;
// each issued byte pushes its hand-written expected line sequence into a
// scoreboard that a separate monitor consumes on every observed pop.
// -----------------------------------------------------------------------------
module tb_aucohl_serial_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [15:0] prescale = 16'd0;
    logic        parity_en = 1'b0;
    logic        parity_odd = 1'b0;
    logic        two_stop = 1'b0;
    logic        tx;
    logic        busy;
    logic        done;

    aucohl_serial_tx_if #(.DW(8)) u_if ();

    aucohl_serial_tx #(.DW(8), .W(16)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .prescale   (prescale),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .two_stop   (two_stop),
        .fifo       (u_if.master),
        .tx         (tx),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // FIFO model storage: stimulus owns wr_ptr, FIFO process owns rd_ptr.
    logic [7:0] mem [0:63];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int rd_count = 0;
    int cyc = 0;
    int last_rd_cyc = 0;
    int gaps [0:63];
    int n_gaps = 0;

    // Scoreboard: expected line sequence ("0"/"1" per bit, first bit first).
    string exp_bits [0:31];
    int    exp_per  [0:31];
    int    exp_wr = 0;
    int    exp_rd = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic fifo_push(input logic [7:0] d);
        mem[wr_ptr % 64] = d;
        wr_ptr++;
    endtask

    task automatic exp_push(input string bits, input int per);
        exp_bits[exp_wr % 32] = bits;
        exp_per[exp_wr % 32]  = per;
        exp_wr++;
    endtask

    task automatic wait_idle(input int max);
        int  c;
        bit  ok;
        c  = 0;
        ok = 1'b0;
        while (c < max && !ok) begin
            tick();
            c++;
            if (!busy && !u_if.fifo_rd) ok = 1'b1;
        end
        chk("wait_idle_in_time", 32'(ok), 32'd1);
    endtask

    task automatic wait_rd(input int target, input int max);
        int c;
        c = 0;
        while (c < max && rd_count < target) begin
            tick();
            c++;
        end
        chk("wait_pop_in_time", 32'(rd_count >= target), 32'd1);
    endtask

    task automatic run_frame(input logic [7:0] d, input string bits, input int per);
        exp_push(bits, per);
        fifo_push(d);
        wait_idle(300);
    endtask

    // FIFO model: pop sampled mid-cycle, applied just after the DUT's edge.
    initial begin
        bit rd_seen;
        u_if.fifo_empty = 1'b1;
        u_if.fifo_rdata = 8'h00;
        forever begin
            @(negedge clk);
            cyc++;
            rd_seen = u_if.fifo_rd;
            if (rd_seen) begin
                rd_count++;
                gaps[n_gaps % 64] = cyc - last_rd_cyc;
                n_gaps++;
                last_rd_cyc = cyc;
            end
            @(posedge clk);
            #1;
            if (rd_seen && rd_ptr != wr_ptr) rd_ptr++;
            u_if.fifo_empty = (rd_ptr == wr_ptr);
            u_if.fifo_rdata = mem[rd_ptr % 64];
        end
    end

    // Monitor: every pop starts one expected frame; reset abandons it.
    initial begin
        bit    have_edge;
        bit    aborted;
        string b;
        int    per;
        have_edge = 1'b0;
        forever begin
            if (!have_edge) @(negedge clk);
            have_edge = 1'b0;
            if (u_if.fifo_rd && !rst) begin
                chk("pop_expected", 32'(exp_wr != exp_rd), 32'd1);
                if (exp_wr != exp_rd) begin
                    b   = exp_bits[exp_rd % 32];
                    per = exp_per[exp_rd % 32];
                    exp_rd++;
                    aborted = 1'b0;
                    for (int i = 0; i < b.len() && !aborted; i++) begin
                        for (int k = 0; k < per && !aborted; k++) begin
                            @(negedge clk);
                            if (rst) begin
                                aborted = 1'b1;
                            end else begin
                                chk($sformatf("tx_bit%0d_clk%0d", i, k), 32'(tx),
                                    32'((b[i] == 8'h31) ? 1 : 0));
                                chk("busy_in_frame", 32'(busy), 32'd1);
                                chk("no_pop_in_frame", 32'(u_if.fifo_rd), 32'd0);
                                chk("no_done_in_frame", 32'(done), 32'd0);
                            end
                        end
                    end
                    if (!aborted) begin
                        @(negedge clk);
                        if (!rst) begin
                            chk("done_pulse", 32'(done), 32'd1);
                            chk("busy_after_frame", 32'(busy), 32'd0);
                            chk("tx_idle_after_frame", 32'(tx), 32'd1);
                            have_edge = 1'b1;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int ng;

        // Reset state
        rst = 1'b1;
        en  = 1'b1;
        repeat (3) tick();
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_fifo_rd", 32'(u_if.fifo_rd), 32'd0);
        en  = 1'b0;
        rst = 1'b0;
        tick();

        // en low: no pop, line idle
        fifo_push(8'hA5);
        repeat (6) tick();
        chk("en_low_no_pop", 32'(rd_count), 32'd0);
        chk("en_low_tx_idle", 32'(tx), 32'd1);

        // 0xA5, prescale 3, no parity, one stop
        prescale = 16'd3;
        exp_push("0101001011", 4);
        en = 1'b1;
        wait_idle(300);

        // prescale 0, parity, two stop
        prescale = 16'd0; parity_en = 1'b1; two_stop = 1'b1;
        parity_odd = 1'b0; run_frame(8'h07, "011100000111", 1);
        parity_odd = 1'b1; run_frame(8'h00, "000000000111", 1);
        parity_odd = 1'b1; run_frame(8'hFF, "011111111111", 1);
        parity_odd = 1'b0; run_frame(8'hFF, "011111111011", 1);

        // Three back-to-back frames, prescale 1
        prescale = 16'd1; parity_en = 1'b0; two_stop = 1'b0;
        base = rd_count;
        ng   = n_gaps;
        exp_push("0100010001", 2);
        exp_push("0010001001", 2);
        exp_push("0110011001", 2);
        fifo_push(8'h11);
        fifo_push(8'h22);
        fifo_push(8'h33);
        wait_idle(300);
        repeat (10) tick();
        chk("b2b_pops", 32'(rd_count - base), 32'd3);
        chk("b2b_gap1", 32'(gaps[(ng + 1) % 64]), 32'd21);
        chk("b2b_gap2", 32'(gaps[(ng + 2) % 64]), 32'd21);
        chk("b2b_fifo_empty", 32'(u_if.fifo_empty), 32'd1);

        // en dropped and prescale changed mid-DATA of 0x55
        prescale = 16'd2;
        base = rd_count;
        exp_push("0101010101", 3);
        fifo_push(8'h55);
        fifo_push(8'h66);
        wait_rd(base + 1, 50);
        repeat (5) tick();
        en = 1'b0;
        prescale = 16'd7;
        wait_idle(300);
        repeat (30) tick();
        chk("en_drop_single_pop", 32'(rd_count - base), 32'd1);
        chk("en_drop_fifo_kept", 32'(wr_ptr - rd_ptr), 32'd1);
        chk("en_drop_tx_idle", 32'(tx), 32'd1);

        // Reset during DATA of 0x66, then a clean 0x77 frame
        prescale = 16'd2;
        exp_push("0011001101", 3);
        en = 1'b1;
        wait_rd(base + 2, 50);
        repeat (6) tick();
        fifo_push(8'h77);
        rst = 1'b1;
        tick();
        chk("midrst_tx", 32'(tx), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_fifo_rd", 32'(u_if.fifo_rd), 32'd0);
        tick();
        chk("midrst_tx_hold", 32'(tx), 32'd1);
        chk("midrst_fifo_rd_hold", 32'(u_if.fifo_rd), 32'd0);
        exp_push("0111011101", 3);
        rst = 1'b0;
        wait_idle(300);
        repeat (5) tick();

        chk("total_pops", 32'(rd_count), 32'd11);
        chk("scoreboard_drained", 32'(exp_wr - exp_rd), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
